// File: rtl/sd_mem_rdport.sv
// ============================================================================
// Module      : sd_mem_rdport
// Description : srdy/drdy read front-end for the two-port behavioural memory.
//               Optional tag sideband enabled by defining SD_MEM_RDPORT_TAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_mem_rdport #(
  parameter int DEPTH   = 256,
  parameter int WIDTH   = 8,
  parameter int ADDR_SZ = $clog2(DEPTH),
  parameter int TAG_SZ  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic [ADDR_SZ-1:0] c_addr,
`ifdef SD_MEM_RDPORT_TAG_EN
  input  logic [TAG_SZ-1:0]  c_tag,
`endif
  output logic               mem_rd_en,
  output logic [ADDR_SZ-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]   mem_d_out,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [WIDTH-1:0]   p_data
`ifdef SD_MEM_RDPORT_TAG_EN
  ,
  output logic [TAG_SZ-1:0]  p_tag
`endif
);

  localparam logic [1:0] LAST_IDX = 2'd2;
  localparam logic [2:0] ENTRIES  = 3'd3;

  logic [1:0]       r_count;
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic             r_inflight;
  logic [WIDTH-1:0] r_data [0:2];

  logic w_push;
  logic w_pop;
  logic w_credit;

  // Credit counts the read already in the memory pipe, so the buffer can
  // never be oversubscribed and c_drdy never depends on p_drdy.
  assign w_credit  = ({1'b0, r_count} + {2'b00, r_inflight}) < ENTRIES;
  assign c_drdy    = reset_n & w_credit;
  assign mem_rd_en = c_srdy & c_drdy;
  assign mem_rd_addr = c_addr;

  assign w_push = r_inflight;
  assign w_pop  = p_srdy & p_drdy;
  assign p_srdy = (r_count != 2'd0);
  assign p_data = r_data[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
    end else begin
      r_inflight <= mem_rd_en;
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? 2'd0 : r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; a zero count already marks every entry invalid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= mem_d_out;
    end
  end

`ifdef SD_MEM_RDPORT_TAG_EN
  logic [TAG_SZ-1:0] r_tag_inflight;
  logic [TAG_SZ-1:0] r_tag [0:2];

  always_ff @(posedge clk) begin
    if (mem_rd_en) begin
      r_tag_inflight <= c_tag;
    end
    if (w_push) begin
      r_tag[r_wr_ptr] <= r_tag_inflight;
    end
  end

  assign p_tag = r_tag[r_rd_ptr];
`endif

endmodule

`default_nettype wire

// File: tb/tb_sd_mem_rdport.sv
// ============================================================================
// Module      : tb_sd_mem_rdport
// Description : Directed self-checking bench for sd_mem_rdport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_mem_rdport;

  localparam int W = 8;
  localparam int A = 8;
  localparam int T = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic [T-1:0] t;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         c_srdy;
  logic         c_drdy;
  logic [A-1:0] c_addr;
  logic         mem_rd_en;
  logic [A-1:0] mem_rd_addr;
  logic [W-1:0] mem_d_out;
  logic         p_srdy;
  logic         p_drdy;
  logic [W-1:0] p_data;
`ifdef SD_MEM_RDPORT_TAG_EN
  logic [T-1:0] c_tag;
  logic [T-1:0] p_tag;
`endif

  logic [W-1:0] mem [0:255];
  exp_t         exp_q [$];
  int           checks = 0;
  int           errors = 0;
  int           pops   = 0;
  logic         last_acc;

  always #5 clk = ~clk;

  sd_mem_rdport dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .c_srdy      (c_srdy),
    .c_drdy      (c_drdy),
    .c_addr      (c_addr),
`ifdef SD_MEM_RDPORT_TAG_EN
    .c_tag       (c_tag),
    .p_tag       (p_tag),
`endif
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_d_out   (mem_d_out),
    .p_srdy      (p_srdy),
    .p_drdy      (p_drdy),
    .p_data      (p_data)
  );

  // Behavioural memory read port: data valid the cycle after rd_en.
  always_ff @(posedge clk) begin
    if (mem_rd_en) mem_d_out <= mem[mem_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at negedge, return at posedge+1.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_acc = c_srdy && c_drdy;
    if (last_acc) begin
      e.d = mem[c_addr];
`ifdef SD_MEM_RDPORT_TAG_EN
      e.t = c_tag;
`else
      e.t = '0;
`endif
      exp_q.push_back(e);
    end
    if (p_srdy && p_drdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_return", 32'(p_srdy), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("p_data_order", 32'(p_data), 32'(e.d));
`ifdef SD_MEM_RDPORT_TAG_EN
        chk("p_tag_order", 32'(p_tag), 32'(e.t));
`endif
        pops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cyc);
    p_drdy = 1'b1;
    c_srdy = 1'b0;
    for (int k = 0; k < max_cyc && (exp_q.size() != 0 || p_srdy); k++) cycle();
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          issued;
    int          pops0;
    logic [W-1:0] held;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3) ^ 8'h5C;
    mem[8'h12] = 8'hA5;

    // Reset: outputs forced low even with a request pending.
    reset_n = 1'b0;
    c_srdy  = 1'b1;
    c_addr  = 8'h00;
    p_drdy  = 1'b0;
`ifdef SD_MEM_RDPORT_TAG_EN
    c_tag   = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p_srdy", 32'(p_srdy), 32'd0);
    chk("rst_c_drdy", 32'(c_drdy), 32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    c_srdy  = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("post_rst_c_drdy", 32'(c_drdy), 32'd1);
    cycle();

    // Single read of 0x12.
    c_srdy = 1'b1;
    c_addr = 8'h12;
    #1;
    chk("single_rd_en", 32'(mem_rd_en), 32'd1);
    chk("single_rd_addr", 32'(mem_rd_addr), 32'h12);
    cycle();
    c_srdy = 1'b0;
    #1;
    chk("single_rd_en_drop", 32'(mem_rd_en), 32'd0);
    chk("single_latency1", 32'(p_srdy), 32'd0);
    cycle();
    chk("single_p_srdy", 32'(p_srdy), 32'd1);
    chk("single_p_data", 32'(p_data), 32'hA5);
    p_drdy = 1'b1;
    cycle();
    chk("single_after_pop", 32'(p_srdy), 32'd0);

    // Full flow: 16 back-to-back reads.
    p_drdy = 1'b1;
    pops0  = pops;
    for (int i = 0; i < 16; i++) begin
      c_srdy = 1'b1;
      c_addr = 8'(i);
      if (i > 0) chk("ff_c_drdy", 32'(c_drdy), 32'd1);
      cycle();
      chk("ff_accept", 32'(last_acc), 32'd1);
    end
    drain(10);
    chk("ff_returns", 32'(pops - pops0), 32'd16);

    // Backpressure: only three accepted while stalled.
    p_drdy = 1'b0;
    issued = 0;
    pops0  = pops;
    for (int k = 0; k < 6; k++) begin
      c_srdy = (issued < 5);
      c_addr = 8'(32'h20 + issued);
      cycle();
      if (last_acc) begin
        issued++;
        if (issued == 3) chk("bp_drdy_after3", 32'(c_drdy), 32'd0);
      end
    end
    chk("bp_accepted", 32'(issued), 32'd3);
    chk("bp_c_drdy_full", 32'(c_drdy), 32'd0);
    chk("bp_p_srdy", 32'(p_srdy), 32'd1);
    chk("bp_head_data", 32'(p_data), 32'(mem[8'h20]));
    held = p_data;
    cycle();
    chk("bp_hold", 32'(p_data), 32'(held));
    p_drdy = 1'b1;
    for (int k = 0; k < 30 && (issued < 5 || exp_q.size() != 0); k++) begin
      c_srdy = (issued < 5);
      c_addr = 8'(32'h20 + issued);
      cycle();
      if (last_acc) issued++;
    end
    c_srdy = 1'b0;
    chk("bp_all_accepted", 32'(issued), 32'd5);
    chk("bp_returns", 32'(pops - pops0), 32'd5);

    // Wrap-around: p_drdy toggles every cycle.
    issued = 0;
    pops0  = pops;
    for (int k = 0; k < 200 && (issued < 20 || exp_q.size() != 0); k++) begin
      p_drdy = k[0];
      c_srdy = (issued < 20);
      c_addr = 8'(32'h40 + issued);
      cycle();
      if (last_acc) issued++;
    end
    c_srdy = 1'b0;
    chk("wrap_accepted", 32'(issued), 32'd20);
    chk("wrap_returns", 32'(pops - pops0), 32'd20);

    // Reset mid-operation with count=2, inflight=1.
    p_drdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c_srdy = 1'b1;
      c_addr = 8'(32'h60 + k);
      cycle();
      chk("mid_pre_accept", 32'(last_acc), 32'd1);
    end
    chk("mid_pre_p_srdy", 32'(p_srdy), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_p_srdy", 32'(p_srdy), 32'd0);
    chk("mid_rst_c_drdy", 32'(c_drdy), 32'd0);
    chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    c_srdy  = 1'b0;
    p_drdy  = 1'b1;
    reset_n = 1'b1;
    #1;
    chk("mid_post_c_drdy", 32'(c_drdy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("mid_no_stale", 32'(p_srdy), 32'd0);
    end
    c_srdy = 1'b1;
    c_addr = 8'h12;
    cycle();
    c_srdy = 1'b0;
    p_drdy = 1'b0;
    cycle();
    chk("mid_fresh_p_srdy", 32'(p_srdy), 32'd1);
    chk("mid_fresh_p_data", 32'(p_data), 32'hA5);
    drain(5);

`ifdef SD_MEM_RDPORT_TAG_EN
    // Tags travel with their data under backpressure.
    p_drdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c_srdy = 1'b1;
      c_addr = 8'(32'h70 + k);
      c_tag  = (k == 0) ? 4'h3 : (k == 1) ? 4'h7 : 4'hC;
      cycle();
      chk("tag_accept", 32'(last_acc), 32'd1);
    end
    c_srdy = 1'b0;
    cycle();
    chk("tag_head", 32'(p_tag), 32'h3);
    chk("tag_head_data", 32'(p_data), 32'(mem[8'h70]));
    drain(10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
